// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage data-memory access with req/ack handshake.
// Optional abort-on-timeout is compiled in when MEM_TIMEOUT_EN is defined.
//
// Ports:
//   clk, reset          pipeline clock (posedge), async active-high reset
//   WB, M               EX/MEM control: WB={RegWrite,MemtoReg}, M={MemRead,MemWrite}
//   ALU_result          EX/MEM address / ALU value
//   write_data          EX/MEM store data
//   RegDst_address      EX/MEM destination register
//   mem_req/we/addr/wdata  data memory request side (registered)
//   mem_ack, mem_rdata  data memory completion and read data
//   stall               combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   _WB, _read_data, _ALU_result, _RegDst_address  MEM/WB register outputs
//   timeout_err         one-cycle abort pulse (constant 0 without MEM_TIMEOUT_EN)
//
// Parameter TIMEOUT_CYCLES: request cycles without ack before abort.

module mem_stage_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  WB,
    input  logic [1:0]  M,
    input  logic [31:0] ALU_result,
    input  logic [31:0] write_data,
    input  logic [4:0]  RegDst_address,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [1:0]  _WB,
    output logic [31:0] _read_data,
    output logic [31:0] _ALU_result,
    output logic [4:0]  _RegDst_address,
    output logic        timeout_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  wb_q, wb_d;
    logic [31:0] rdd_q, rdd_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  rd_q, rd_d;
    logic        stall_c;

    logic        timeout_hit;
    logic        aborted;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_q;

    // Counter sits at zero outside ACCESS, so it is clear on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == S_ACCESS) ? cnt_q + 1'b1 : '0;
            tmo_q <= timeout_hit;
        end
    end

    // An ack in the last allowed cycle takes priority over the abort.
    assign timeout_hit = (state_q == S_ACCESS) && !mem_ack && (cnt_q == LIMIT);
    assign aborted     = tmo_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
    assign aborted        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wb_d    = wb_q;
        rdd_d   = rdd_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        stall_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (M == 2'b00) begin
                    wb_d  = WB;
                    rdd_d = 32'd0;
                    alu_d = ALU_result;
                    rd_d  = RegDst_address;
                end else begin
                    stall_c = 1'b1;
                    addr_d  = {ALU_result[31:2], 2'b00};
                    wdata_d = write_data;
                    // M==11 is treated as a store.
                    we_d    = M[0];
                    wb_d    = 2'b00;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                stall_c = 1'b1;
                wb_d    = 2'b00;
                if (mem_ack) begin
                    rdata_d = we_q ? 32'd0 : mem_rdata;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    rdata_d = 32'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // EX/MEM still holds the completed instruction here.
                wb_d    = aborted ? 2'b00 : WB;
                rdd_d   = rdata_q;
                alu_d   = ALU_result;
                rd_d    = RegDst_address;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            wb_q    <= 2'b00;
            rdd_q   <= 32'd0;
            alu_q   <= 32'd0;
            rd_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wb_q    <= wb_d;
            rdd_q   <= rdd_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
        end
    end

    // Request is high exactly while in ACCESS; state is registered.
    assign mem_req         = (state_q == S_ACCESS);
    assign mem_we          = we_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    // Reset must release the pipeline at once, even with M!=00.
    assign stall           = stall_c & ~reset;
    assign _WB             = wb_q;
    assign _read_data      = rdd_q;
    assign _ALU_result     = alu_q;
    assign _RegDst_address = rd_q;
    assign timeout_err     = aborted;

endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: directed self-checking bench for mem_stage_access.
// Timeout checks are selected by MEM_TIMEOUT_EN, matching the RTL build.

module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  WB, M;
    logic [31:0] ALU_result, write_data;
    logic [4:0]  RegDst_address;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [1:0]  _WB;
    logic [31:0] _read_data, _ALU_result;
    logic [4:0]  _RegDst_address;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int stall_n = 0;
    int req_n = 0;
    int tmo_n = 0;

    mem_stage_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .WB(WB),
        .M(M),
        .ALU_result(ALU_result),
        .write_data(write_data),
        .RegDst_address(RegDst_address),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .stall(stall),
        ._WB(_WB),
        ._read_data(_read_data),
        ._ALU_result(_ALU_result),
        ._RegDst_address(_RegDst_address),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample stall/req/timeout at the falling edge, then step
    // just past the rising edge so checks see settled registers.
    task automatic tick();
        @(negedge clk);
        stall_n += int'(stall);
        req_n   += int'(mem_req);
        tmo_n   += int'(timeout_err);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        stall_n = 0;
        req_n   = 0;
        tmo_n   = 0;
    endtask

    task automatic set_op(input logic [1:0] m, input logic [1:0] wb,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd);
        M              = m;
        WB             = wb;
        ALU_result     = alu;
        write_data     = wd;
        RegDst_address = rd;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        set_op(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);

        // Reset state
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb", 32'(_WB), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: ALU pass-through, one edge latency, no stall
        set_op(2'b00, 2'b10, 32'h1234, 32'd0, 5'd5);
        clr_cnt();
        tick();
        chk("alu_wb", 32'(_WB), 32'h2);
        chk("alu_res", _ALU_result, 32'h1234);
        chk("alu_rd", 32'(_RegDst_address), 32'd5);
        chk("alu_rdata", _read_data, 32'd0);
        chk("alu_stall", 32'(stall_n), 32'd0);

        // Ack while idle with no memory op is ignored
        set_op(2'b00, 2'b00, 32'h0, 32'd0, 5'd0);
        mem_ack = 1'b1;
        clr_cnt();
        tick();
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_req", 32'(req_n), 32'd0);
        chk("idle_ack_stall", 32'(stall_n), 32'd0);

        // 2: load, ack on the third request cycle
        set_op(2'b10, 2'b11, 32'h100, 32'd0, 5'd8);
        clr_cnt();
        #1;
        chk("ld_stall_idle", 32'(stall), 32'd1);
        tick();
        chk("ld_req", 32'(mem_req), 32'd1);
        chk("ld_addr", mem_addr, 32'h100);
        chk("ld_we", 32'(mem_we), 32'd0);
        chk("ld_bubble", 32'(_WB), 32'd0);
        tick();
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        chk("ld_req_drop", 32'(mem_req), 32'd0);
        tick();
        // 5: the next instruction follows straight away
        set_op(2'b00, 2'b10, 32'h55, 32'd0, 5'd7);
        chk("ld_rdata", _read_data, 32'hDEADBEEF);
        chk("ld_wb", 32'(_WB), 32'h3);
        chk("ld_rd", 32'(_RegDst_address), 32'd8);
        chk("ld_req_cyc", 32'(req_n), 32'd3);
        chk("ld_stall_cyc", 32'(stall_n), 32'd4);
        tick();
        chk("b2b_wb", 32'(_WB), 32'h2);
        chk("b2b_alu", _ALU_result, 32'h55);
        chk("b2b_rd", 32'(_RegDst_address), 32'd7);
        chk("b2b_req_cyc", 32'(req_n), 32'd3);
        chk("b2b_stall_cyc", 32'(stall_n), 32'd4);

        // 3: store with unaligned address, ack in first request cycle,
        // ack held through DONE must not restart the access
        set_op(2'b01, 2'b00, 32'h2003, 32'hA5A5A5A5, 5'd3);
        clr_cnt();
        tick();
        chk("st_addr", mem_addr, 32'h2000);
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_wdata", mem_wdata, 32'hA5A5A5A5);
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        set_op(2'b00, 2'b00, 32'h0, 32'd0, 5'd0);
        chk("st_rdata", _read_data, 32'd0);
        chk("st_alu", _ALU_result, 32'h2003);
        chk("st_stall_cyc", 32'(stall_n), 32'd2);
        chk("st_req_cyc", 32'(req_n), 32'd1);

        // 3b: M=11 is a store
        set_op(2'b11, 2'b00, 32'h3000, 32'h0F0F0F0F, 5'd0);
        tick();
        chk("mw_we", 32'(mem_we), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("mw_rdata", _read_data, 32'd0);

        // 4: reset while a load is outstanding
        set_op(2'b10, 2'b11, 32'h300, 32'd0, 5'd9);
        tick();
        chk("rm_req_pre", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_req", 32'(mem_req), 32'd0);
        chk("rm_stall", 32'(stall), 32'd0);
        chk("rm_wb", 32'(_WB), 32'd0);
        chk("rm_rdata", _read_data, 32'd0);
        chk("rm_alu", _ALU_result, 32'd0);
        chk("rm_rd", 32'(_RegDst_address), 32'd0);
        chk("rm_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_op(2'b10, 2'b11, 32'h400, 32'd0, 5'd9);
        #1;
        chk("rm_idle_stall", 32'(stall), 32'd1);
        chk("rm_idle_req", 32'(mem_req), 32'd0);
        tick();
        chk("rm_new_addr", mem_addr, 32'h400);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        tick();
        set_op(2'b00, 2'b00, 32'h0, 32'd0, 5'd0);
        chk("rm_new_rdata", _read_data, 32'hCAFEF00D);

`ifdef MEM_TIMEOUT_EN
        // 6: no ack, abort after 4 request cycles
        set_op(2'b10, 2'b11, 32'h500, 32'd0, 5'd4);
        clr_cnt();
        for (int i = 0; i < 5; i++) tick();
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_err", 32'(timeout_err), 32'd1);
        tick();
        set_op(2'b00, 2'b00, 32'h0, 32'd0, 5'd0);
        chk("to_err_clr", 32'(timeout_err), 32'd0);
        chk("to_wb", 32'(_WB), 32'd0);
        chk("to_rdata", _read_data, 32'd0);
        chk("to_req_cyc", 32'(req_n), 32'd4);
        chk("to_stall_cyc", 32'(stall_n), 32'd5);
        chk("to_pulse", 32'(tmo_n), 32'd1);

        // Ack in the last allowed cycle beats the abort
        set_op(2'b10, 2'b11, 32'h600, 32'd0, 5'd4);
        clr_cnt();
        for (int i = 0; i < 4; i++) tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h600D600D;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        tick();
        set_op(2'b00, 2'b00, 32'h0, 32'd0, 5'd0);
        chk("lim_rdata", _read_data, 32'h600D600D);
        chk("lim_wb", 32'(_WB), 32'h3);
        chk("lim_pulse", 32'(tmo_n), 32'd0);
`else
        // Without the timeout, the access waits as long as needed
        set_op(2'b10, 2'b11, 32'h500, 32'd0, 5'd4);
        clr_cnt();
        for (int i = 0; i < 11; i++) tick();
        chk("wait_req", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        tick();
        set_op(2'b00, 2'b00, 32'h0, 32'd0, 5'd0);
        chk("wait_rdata", _read_data, 32'h0BADF00D);
        chk("wait_wb", 32'(_WB), 32'h3);
        chk("wait_req_cyc", 32'(req_n), 32'd11);
        chk("wait_tmo", 32'(tmo_n), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
